// File: rtl/axi_cfg_master.sv
// axi_cfg_master: scripted single-beat AXI4 master for simulation tops.
//   Takes one register read/write on the cmd_* port, issues it as a single
//   AXI4 beat on the aw/w/b or ar/r channels, and returns data and response
//   on the rsp_* port. Only one transaction is in flight at a time.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   cmd_*                    command in (valid/ready)
//   rsp_*                    response out (valid/ready)
//   aw_*, w_*, b_*, ar_*, r_* flattened AXI4 master channels
//   timeout_o                sticky watchdog flag
// Build option: define AXI_CFG_MASTER_TIMEOUT_EN to enable the watchdog;
//   without it timeout_o is tied low and no counter exists.
module axi_cfg_master #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 64,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic                        rsp_write_o,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                  rsp_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
  output logic [7:0]                  aw_len,
  output logic [2:0]                  aw_size,
  output logic [1:0]                  aw_burst,
  output logic                        aw_lock,
  output logic [3:0]                  aw_cache,
  output logic [2:0]                  aw_prot,
  output logic [3:0]                  aw_qos,
  output logic [3:0]                  aw_region,
  output logic [5:0]                  aw_atop,
  output logic [AXI_USER_WIDTH-1:0]   aw_user,
  output logic                        aw_valid,
  input  logic                        aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
  output logic                        w_last,
  output logic [AXI_USER_WIDTH-1:0]   w_user,
  output logic                        w_valid,
  input  logic                        w_ready,
  input  logic [AXI_ID_WIDTH-1:0]     b_id,
  input  logic [1:0]                  b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   b_user,
  input  logic                        b_valid,
  output logic                        b_ready,
  output logic [AXI_ID_WIDTH-1:0]     ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]                  ar_len,
  output logic [2:0]                  ar_size,
  output logic [1:0]                  ar_burst,
  output logic                        ar_lock,
  output logic [3:0]                  ar_cache,
  output logic [2:0]                  ar_prot,
  output logic [3:0]                  ar_qos,
  output logic [3:0]                  ar_region,
  output logic [AXI_USER_WIDTH-1:0]   ar_user,
  output logic                        ar_valid,
  input  logic                        ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]                  r_resp,
  input  logic                        r_last,
  input  logic [AXI_USER_WIDTH-1:0]   r_user,
  input  logic                        r_valid,
  output logic                        r_ready,
  output logic                        timeout_o
);
  localparam logic [2:0] SIZE = 3'($clog2(AXI_DATA_WIDTH/8));

  typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RDATA, RSP} state_e;
  state_e state_q;
  logic   aw_done_q, w_done_q;
  logic   aw_hs, w_hs;

  // Single-beat INCR, everything else zero.
  assign aw_id = AXI_ID;      assign ar_id = AXI_ID;
  assign aw_len = '0;         assign ar_len = '0;
  assign aw_size = SIZE;      assign ar_size = SIZE;
  assign aw_burst = 2'b01;    assign ar_burst = 2'b01;
  assign aw_lock = 1'b0;      assign ar_lock = 1'b0;
  assign aw_cache = '0;       assign ar_cache = '0;
  assign aw_prot = '0;        assign ar_prot = '0;
  assign aw_qos = '0;         assign ar_qos = '0;
  assign aw_region = '0;      assign ar_region = '0;
  assign aw_atop = '0;
  assign aw_user = '0;        assign ar_user = '0;
  assign w_user = '0;
  assign w_last = 1'b1;

  // IDs and user sidebands of responses carry nothing for a single-ID master.
  logic unused_rsp_side;
  assign unused_rsp_side = ^{b_id, b_user, r_id, r_user};

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_resp_o  <= '0;
      aw_addr     <= '0;
      aw_valid    <= 1'b0;
      w_data      <= '0;
      w_strb      <= '0;
      w_valid     <= 1'b0;
      b_ready     <= 1'b0;
      ar_addr     <= '0;
      ar_valid    <= 1'b0;
      r_ready     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            if (cmd_write_i) begin
              aw_addr   <= cmd_addr_i;
              w_data    <= cmd_wdata_i;
              w_strb    <= cmd_strb_i;
              aw_valid  <= 1'b1;
              w_valid   <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WRITE;
            end else begin
              ar_addr  <= cmd_addr_i;
              ar_valid <= 1'b1;
              state_q  <= READ;
            end
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        WRITE: begin
          // aw and w retire independently; move on once both have.
          if (aw_hs) begin aw_valid <= 1'b0; aw_done_q <= 1'b1; end
          if (w_hs)  begin w_valid  <= 1'b0; w_done_q  <= 1'b1; end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            b_ready <= 1'b1;
            state_q <= BRESP;
          end
        end
        BRESP: begin
          if (b_valid) begin
            b_ready     <= 1'b0;
            rsp_write_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= b_resp;
            rsp_valid_o <= 1'b1;
            state_q     <= RSP;
          end
        end
        READ: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state_q  <= RDATA;
          end
        end
        RDATA: begin
          if (r_valid) begin
            r_ready     <= 1'b0;
            rsp_write_o <= 1'b0;
            rsp_rdata_o <= r_data;
            // A single-beat read must end with r_last; anything else is a slave error.
            rsp_resp_o  <= r_last ? r_resp : 2'b10;
            rsp_valid_o <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  // Counts cycles spent in the current waiting state. The first cycle of a
  // new state loads 1, so the flag rises exactly TIMEOUT_CYCLES cycles after
  // entering the state. The transaction itself is never aborted.
  state_e      prev_q;
  logic [31:0] wd_cnt_q, wd_cnt_nxt;
  logic        busy;

  assign busy       = (state_q == WRITE) || (state_q == BRESP) ||
                      (state_q == READ)  || (state_q == RDATA);
  assign wd_cnt_nxt = (state_q != prev_q) ? 32'd1 : wd_cnt_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= IDLE;
      wd_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else begin
      prev_q <= state_q;
      if (busy) begin
        wd_cnt_q <= wd_cnt_nxt;
        if (wd_cnt_nxt >= 32'(TIMEOUT_CYCLES)) timeout_o <= 1'b1;
      end else begin
        wd_cnt_q <= '0;
      end
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_cfg_master.sv
module tb_axi_cfg_master;
  localparam int AW = 64, DW = 64, IW = 4, UW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_strb = '0;
  logic rsp_valid, rsp_ready = 0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [IW-1:0] aw_id, ar_id, b_id = '0, r_id = '0;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst;
  logic aw_lock, ar_lock;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [5:0] aw_atop;
  logic [UW-1:0] aw_user, ar_user, w_user, b_user = '0, r_user = '0;
  logic aw_valid, aw_ready = 0, w_valid, w_ready = 0, w_last;
  logic [DW-1:0] w_data;
  logic [DW/8-1:0] w_strb;
  logic [1:0] b_resp = '0, r_resp = '0;
  logic b_valid = 0, b_ready, ar_valid, ar_ready = 0;
  logic [DW-1:0] r_data = '0;
  logic r_last = 0, r_valid = 0, r_ready, timeout;

  axi_cfg_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                   .AXI_USER_WIDTH(UW), .AXI_ID(4'd0), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot),
    .aw_qos(aw_qos), .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user),
    .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
    .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .r_valid(r_valid), .r_ready(r_ready),
    .timeout_o(timeout)
  );

  int ncmp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, set by the main sequence.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_never = 0;
  logic [1:0] b_resp_v = 0, r_resp_v = 0;
  logic [DW-1:0] r_data_v = '0;
  logic r_last_v = 1;

  // Slave: readies/valids change on the falling edge after N waiting cycles.
  initial begin
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    forever begin
      @(negedge clk);
      if (aw_valid) begin aw_ready = (aw_c >= aw_dly); aw_c++; end else begin aw_ready = 0; aw_c = 0; end
      if (w_valid)  begin w_ready  = (w_c >= w_dly);   w_c++;  end else begin w_ready = 0;  w_c = 0;  end
      if (ar_valid) begin ar_ready = (ar_c >= ar_dly); ar_c++; end else begin ar_ready = 0; ar_c = 0; end
      if (b_ready && !b_never) begin b_valid = (b_c >= b_dly); b_c++; end else begin b_valid = 0; b_c = 0; end
      if (r_ready) begin r_valid = (r_c >= r_dly); r_c++; end else begin r_valid = 0; r_c = 0; end
      b_resp = b_resp_v; r_resp = r_resp_v; r_data = r_data_v; r_last = r_last_v;
    end
  end

  // Monitor: handshake counts, captured beats, and valid/payload stability.
  int b_hs = 0, r_hs = 0, aw_vcyc = 0, w_vcyc = 0, proto_err = 0;
  logic [AW-1:0] cap_aw = '0, cap_ar = '0;
  logic [DW-1:0] cap_wd = '0;
  logic [DW/8-1:0] cap_ws = '0;
  initial begin
    bit aw_p = 0, w_p = 0, ar_p = 0;
    logic [AW-1:0] p_aw = '0, p_ar = '0;
    logic [DW-1:0] p_wd = '0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (aw_valid) aw_vcyc++;
        if (w_valid) w_vcyc++;
        if (b_valid && b_ready) b_hs++;
        if (r_valid && r_ready) r_hs++;
        if (aw_valid && aw_ready) cap_aw = aw_addr;
        if (ar_valid && ar_ready) cap_ar = ar_addr;
        if (w_valid && w_ready) begin cap_wd = w_data; cap_ws = w_strb; end
        aw_p = aw_valid && !aw_ready; p_aw = aw_addr;
        w_p  = w_valid && !w_ready;   p_wd = w_data;
        ar_p = ar_valid && !ar_ready; p_ar = ar_addr;
      end else begin
        aw_p = 0; w_p = 0; ar_p = 0;
      end
      @(negedge clk);
      if (rst_n) begin
        if (aw_p && !(aw_valid && aw_addr == p_aw)) proto_err++;
        if (w_p && !(w_valid && w_data == p_wd)) proto_err++;
        if (ar_p && !(ar_valid && ar_addr == p_ar)) proto_err++;
      end
    end
  end

  // Issue one command, wait for its response, hold rsp_ready low 'hold' cycles.
  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW/8-1:0] s, input int hold, output int lat,
                         output logic rw, output logic [DW-1:0] rd, output logic [1:0] rr);
    int n;
    bit seen;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1 cmd_valid = 0;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (rsp_valid) seen = 1;
    end
    chk("rsp_wait_timeout", {63'd0, seen}, 64'd1);
    lat = n; rw = rsp_write; rd = rsp_rdata; rr = rsp_resp;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_resp", {62'd0, rsp_resp}, {62'd0, rr});
      chk("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
  endtask

  initial begin
    int lat, b0, r0, a0, w0, first_to, n;
    logic rw;
    logic [DW-1:0] rd;
    logic [1:0] rr;

    // Reset state
    #12;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 0);
    chk("rst_aw_valid", {63'd0, aw_valid}, 0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 0);
    chk("rst_aw_addr", aw_addr, 0);
    chk("rst_timeout", {63'd0, timeout}, 0);
    chk("aw_size", {61'd0, aw_size}, 3);
    chk("aw_burst", {62'd0, aw_burst}, 1);
    chk("w_last", {63'd0, w_last}, 1);
    chk("ar_len", {56'd0, ar_len}, 0);
    @(negedge clk); rst_n = 1;

    // Zero-wait write
    b0 = b_hs; a0 = aw_vcyc; w0 = w_vcyc;
    run_txn(1, 64'h5000_0050, 64'h1, 8'hFF, 0, lat, rw, rd, rr);
    chk("wr_latency", lat, 3);
    chk("wr_resp", {62'd0, rr}, 0);
    chk("wr_rsp_write", {63'd0, rw}, 1);
    chk("wr_aw_cycles", aw_vcyc - a0, 1);
    chk("wr_w_cycles", w_vcyc - w0, 1);
    chk("wr_aw_addr", cap_aw, 64'h5000_0050);
    chk("wr_w_data", cap_wd, 64'h1);

    // w accepted two cycles before aw
    aw_dly = 2; w_dly = 0; b0 = b_hs; a0 = aw_vcyc; w0 = w_vcyc;
    run_txn(1, 64'h5000_0058, 64'hAB, 8'h0F, 0, lat, rw, rd, rr);
    chk("wfirst_aw_cycles", aw_vcyc - a0, 3);
    chk("wfirst_w_cycles", w_vcyc - w0, 1);
    chk("wfirst_b_hs", b_hs - b0, 1);
    chk("wfirst_resp", {62'd0, rr}, 0);
    chk("wfirst_latency", lat, 5);
    aw_dly = 0;

    // Reads, r_last good then bad
    r_data_v = 64'hDEAD_BEEF_0123_4567; r_resp_v = 0; r_last_v = 1;
    run_txn(0, 64'h8000_0000, 0, 0, 0, lat, rw, rd, rr);
    chk("rd_data", rd, 64'hDEAD_BEEF_0123_4567);
    chk("rd_resp", {62'd0, rr}, 0);
    chk("rd_rsp_write", {63'd0, rw}, 0);
    chk("rd_latency", lat, 3);
    chk("rd_ar_addr", cap_ar, 64'h8000_0000);
    r_last_v = 0;
    run_txn(0, 64'h8000_0000, 0, 0, 0, lat, rw, rd, rr);
    chk("rd_nolast_resp", {62'd0, rr}, 2);
    r_last_v = 1;

    // Response backpressure, then next command accepted right away
    run_txn(0, 64'h8000_0010, 0, 0, 5, lat, rw, rd, rr);
    @(negedge clk);
    chk("bp_cmd_ready_after", {63'd0, cmd_ready}, 1);

    // Randomized traffic against a cycle/response model
    for (int i = 0; i < 30; i++) begin
      bit wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [7:0] s;
      int exp_lat;
      logic [1:0] exp_resp;
      wr = $urandom_range(0, 1);
      a = {$urandom, $urandom & 32'hFFFF_FFF8};
      d = {$urandom, $urandom};
      s = 8'($urandom);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_resp_v = 2'($urandom); r_resp_v = 2'($urandom); r_last_v = ($urandom_range(0, 3) != 0);
      r_data_v = {$urandom, $urandom};
      if (wr) begin
        exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        exp_resp = b_resp_v;
      end else begin
        exp_lat = 3 + ar_dly + r_dly;
        exp_resp = r_last_v ? r_resp_v : 2'b10;
      end
      run_txn(wr, a, d, s, $urandom_range(0, 2), lat, rw, rd, rr);
      chk("rnd_latency", lat, exp_lat);
      chk("rnd_resp", {62'd0, rr}, {62'd0, exp_resp});
      chk("rnd_write", {63'd0, rw}, {63'd0, wr});
      chk("rnd_rdata", rd, wr ? 64'd0 : r_data_v);
      if (wr) begin
        chk("rnd_aw_addr", cap_aw, a);
        chk("rnd_w_data", cap_wd, d);
        chk("rnd_w_strb", {56'd0, cap_ws}, {56'd0, s});
      end else begin
        chk("rnd_ar_addr", cap_ar, a);
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; b_resp_v = 0; r_last_v = 1;

    // Slave never responds: watchdog, then reset while waiting in BRESP
    b_never = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 64'h5000_0060; cmd_wdata = 64'h7; cmd_strb = 8'hFF;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 cmd_valid = 0;
    n = 0;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    chk("bresp_entered", {63'd0, b_ready}, 1);
    first_to = 0;
    for (int j = 1; j <= 25; j++) begin
      if (timeout && first_to == 0) first_to = j;
      if (j < 25) @(negedge clk);
    end
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    chk("timeout_first_cycle", first_to, 17);
    chk("timeout_sticky", {63'd0, timeout}, 1);
`else
    chk("timeout_never", first_to, 0);
    chk("timeout_low", {63'd0, timeout}, 0);
`endif
    chk("bresp_still_waiting", {63'd0, b_ready}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_b_ready", {63'd0, b_ready}, 0);
    chk("arst_aw_valid", {63'd0, aw_valid}, 0);
    chk("arst_w_valid", {63'd0, w_valid}, 0);
    chk("arst_ar_valid", {63'd0, ar_valid}, 0);
    chk("arst_r_ready", {63'd0, r_ready}, 0);
    chk("arst_cmd_ready", {63'd0, cmd_ready}, 0);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 0);
    chk("arst_timeout", {63'd0, timeout}, 0);
    @(negedge clk); rst_n = 1; b_never = 0;
    b0 = b_hs;
    run_txn(1, 64'h5000_0068, 64'h55, 8'hFF, 0, lat, rw, rd, rr);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_resp", {62'd0, rr}, 0);
    chk("post_rst_b_hs", b_hs - b0, 1);
    chk("post_rst_aw_addr", cap_aw, 64'h5000_0068);

    chk("proto_stability", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/axi_cfg_master.md
Name: axi_cfg_master

Overview:
- Scripted single-beat AXI4 master that replaces hand-driven slave-port stimulus in simulation tops.
- Accepts register read/write commands on a valid/ready command port.
- Issues each command as one legal AXI4 transaction into a crossbar slave port (e.g. slave port 0, toward the accelerator config space).
- Returns read data and response code on a valid/ready response port.
- One outstanding transaction at a time.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width (must be 32 or 64).
- AXI_ID_WIDTH, 4, ID width.
- AXI_USER_WIDTH, 64, user width.
- AXI_ID, 0, constant ID driven on aw_id/ar_id.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted this cycle if valid.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AXI_ADDR_WIDTH  byte address.
- cmd_wdata_i  in  AXI_DATA_WIDTH  write data.
- cmd_strb_i  in  AXI_DATA_WIDTH/8  write strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_write_o  out  1  response belongs to a write.
- rsp_rdata_o  out  AXI_DATA_WIDTH  read data (0 for writes).
- rsp_resp_o  out  2  AXI BRESP/RRESP.
- aw_*, w_*, b_*, ar_*, r_*  master-side AXI4 channels, flattened, full signal set.
- timeout_o  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset: clk_i is the only clock; rst_ni is asynchronous, active-low.
  - All valid/ready outputs 0; rsp_* 0; address/data/strb outputs 0; state IDLE.
  - timeout_o 0.
- Constant fields:
  - aw_len/ar_len = 0.
  - aw_size/ar_size = log2(AXI_DATA_WIDTH/8).
  - burst INCR; w_last = 1.
  - id = AXI_ID; user, prot, cache, qos, region, lock, atop all 0.
- Output registering: all AXI outputs are registered.
- State IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch addr/wdata/strb/write.
  - Write command -> WRITE; read command -> READ.
- State WRITE:
  - aw_valid and w_valid are both 1 from the first WRITE cycle (1 cycle after command acceptance).
  - Each valid drops independently the cycle after its own handshake. Two done flags track completion.
  - aw and w may complete in the same or different cycles, in either order.
  - When both are done -> BRESP.
- State BRESP:
  - b_ready = 1.
  - On b_valid: capture b_resp, rdata = 0 -> RSP.
- State READ:
  - ar_valid = 1 until ar_ready -> RDATA.
- State RDATA:
  - r_ready = 1.
  - On r_valid: capture r_data and r_resp -> RSP.
  - If r_last = 0, force rsp_resp_o = SLVERR (2'b10).
- State RSP:
  - rsp_valid_o = 1; response fields held stable.
  - On rsp_ready_i -> IDLE; cmd_ready_o reasserts the next cycle.
- Handshake rules:
  - No AXI valid deasserts before its handshake.
  - Address/data fields stay stable while their valid is high.
  - b_ready and r_ready are asserted only in BRESP and RDATA respectively.
  - Any AXI valid input arriving outside its state is ignored (not ready).
- Latency, zero-wait slave: write response 3 cycles after command acceptance; read response 3 cycles.
- Back-to-back throughput: one command per 4 cycles minimum.
- Mid-operation reset: in-flight transaction abandoned, all outputs return to reset values immediately.

Optional Feature:
- Macro: AXI_CFG_MASTER_TIMEOUT_EN.
- Enabled:
  - A 32-bit counter clears on every state change and increments while in WRITE, BRESP, READ or RDATA.
  - On reaching TIMEOUT_CYCLES, timeout_o sets (sticky until reset).
  - The transaction is not aborted (AXI legality preserved).
- Disabled:
  - No counter is instantiated; timeout_o is tied to 0.

Test Plan:
- Write 0x5000_0050 <- 0x1, strb 0xFF, slave always ready with B OKAY:
  - aw_valid/w_valid high exactly 1 cycle.
  - aw_size = 3.
  - rsp_valid 3 cycles after accept, rsp_resp = 0, rsp_write = 1.
- Write, slave accepts w 2 cycles before aw:
  - w_valid drops after its handshake.
  - aw_valid held until aw_ready.
  - Exactly one b_ready handshake; rsp_resp = 0.
- Read 0x8000_0000, slave returns 0xDEAD_BEEF_0123_4567 OKAY with r_last = 1:
  - rsp_rdata matches, rsp_resp = 0.
  - Repeat with r_last = 0 -> rsp_resp = 2.
- Backpressure on response: rsp_ready low 5 cycles:
  - rsp fields stable, cmd_ready_o low throughout.
  - Next command accepted the cycle after rsp_ready.
- Assert rst_ni low while in BRESP:
  - All valid/ready outputs 0 asynchronously.
  - After release, a new write completes normally.
- With AXI_CFG_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never asserts b_valid:
  - timeout_o rises 16 cycles after entering BRESP and stays high.
  - Without the macro, timeout_o stays 0.
